mc_main_control: RTL and testbench
==================================

# mc_main_control

Main sequencing FSM for the 16-bit multi-cycle processor. Walks each instruction through fetch, decode, execute, memory and write-back. Emits every datapath write-enable and mux select, plus the 3-bit `alu_op` consumed by the ALU control decoder. Stalls on a memory-ready handshake and stops on HALT.

## Interface
- `MEM_WAIT_MAX`, 0: optional memory-timeout bound in cycles; 0 disables the timeout.
- `clk`  in  1  single system clock. One clock; reset is synchronous and active-high.
- `rst`  in  1  synchronous, active-high reset.
- `opcode`  in  4  IR[15:12], sampled in DECODE.
- `mem_ready`  in  1  memory completes the current read/write this cycle.
- `pc_write`  out  1  unconditional PC load.
- `pc_write_cond`  out  1  PC load gated by ALU zero in the datapath.
- `pc_src`  out  2  00 ALU result, 01 ALUOut, 10 jump target.
- `iord`  out  1  memory address: 0 = PC, 1 = ALUOut.
- `mem_read` / `mem_write`  out  1 each  memory strobes.
- `ir_write`  out  1  IR load.
- `reg_write`  out  1  register-file write.
- `reg_dst`  out  1  0 = rt, 1 = rd.
- `mem_to_reg`  out  1  write-back source: 0 = ALUOut, 1 = MDR.
- `alu_src_a`  out  1  0 = PC, 1 = A.
- `alu_src_b`  out  2  00 B, 01 constant 1, 10 sign-ext imm, 11 zero-ext imm.
- `alu_op`  out  3  000 add, 001 sub, 011 R-type (func decides), 110 and-imm, 111 or-imm.
- `halted`  out  1  high while in HALT.
- `illegal_op`  out  1  sticky illegal-opcode flag.

## Operation
- **Opcodes:**
  - 0000 R-type
  - 0001 ADDI
  - 0010 ANDI
  - 0011 ORI
  - 0100 LW
  - 0101 SW
  - 0110 BEQ
  - 0111 JMP
  - 1111 HALT
  - all others illegal.
- **States:** FETCH, DECODE, EXEC_R, EXEC_I, R_WB, I_WB, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, BRANCH, JUMP, HALT, TRAP.
- **Outputs:** Moore outputs, decoded from the state register only. Any output not listed for a state is 0.
- **FETCH:** mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=000, pc_src=00. ir_write and pc_write are asserted only in the cycle mem_ready=1. Stays in FETCH until mem_ready.
- **DECODE:** alu_src_a=0, alu_src_b=10, alu_op=000 (branch target into ALUOut). Next state by opcode:
  - R-type → EXEC_R
  - ADDI/ANDI/ORI → EXEC_I
  - LW/SW → MEM_ADDR
  - BEQ → BRANCH
  - JMP → JUMP
  - HALT → HALT
  - illegal → TRAP or FETCH (see Configuration).
- **EXEC_R:** alu_src_a=1, alu_src_b=00, alu_op=011 → R_WB. **R_WB:** reg_write=1, reg_dst=1, mem_to_reg=0 → FETCH.
- **EXEC_I:** alu_src_a=1.
  - ADDI: alu_src_b=10, alu_op=000.
  - ANDI: alu_src_b=11, alu_op=110.
  - ORI: alu_src_b=11, alu_op=111.
  - Next → I_WB. **I_WB:** reg_write=1, reg_dst=0, mem_to_reg=0 → FETCH.
- **MEM_ADDR:** alu_src_a=1, alu_src_b=10, alu_op=000. LW → MEM_RD; SW → MEM_WR.
- **MEM_RD:** mem_read=1, iord=1. Held until mem_ready, then → MEM_WB. **MEM_WB:** reg_write=1, reg_dst=0, mem_to_reg=1 → FETCH.
- **MEM_WR:** mem_write=1, iord=1. Held until mem_ready, then → FETCH.
- **BRANCH:** alu_src_a=1, alu_src_b=00, alu_op=001, pc_write_cond=1, pc_src=01 → FETCH.
- **JUMP:** pc_write=1, pc_src=10 → FETCH.
- **HALT:** halted=1, all strobes 0. Terminal until rst.
- **Opcode latch:** opcode is latched into an internal register in DECODE. Later states use the latched copy, never the live input.
- **Memory timeout:** if MEM_WAIT_MAX>0 and a memory state waits MEM_WAIT_MAX cycles without mem_ready, go to TRAP (macro on) or HALT (macro off).

## Timing
- **Reset:** rst high at a clock edge → state=FETCH, latched opcode=0, illegal_op=0, wait counter=0. While rst is high, every output is forced to 0, including FETCH's mem_read. Reset mid-instruction abandons the instruction with no partial writes after the reset edge.
- **Cycles per instruction, zero-wait memory:**
  - R-type/I-type: 4
  - LW: 5
  - SW: 4
  - BEQ/JMP: 3
- Each wait cycle on mem_ready adds one cycle in FETCH, MEM_RD or MEM_WR.
- mem_ready is ignored in every state except FETCH, MEM_RD and MEM_WR.
- The wait counter clears on every state change. It saturates and never wraps.

## Configuration
- **`MC_CTRL_ILLEGAL_TRAP_EN` defined:**
  - An illegal opcode or a memory timeout enters TRAP: illegal_op=1 (sticky), halted=1, all strobes 0.
  - TRAP is left only by rst.
- **Undefined:**
  - An illegal opcode is a NOP: DECODE → FETCH.
  - illegal_op is tied to 0 and TRAP is unreachable.

## Structure
- **Package `mc_pkg`:** state enum, opcode constants, alu_op codes, pc_src and alu_src_b encodings. Shared with the datapath and ALU control.
- **Sub-module `mc_ctrl_decode`:** combinational state + latched opcode → control word. The top level holds the state register, next-state logic, opcode latch and wait counter.

## Test plan
- Reset, then R-type opcode 0000 with mem_ready tied 1 → states FETCH, DECODE, EXEC_R, R_WB. Exactly one reg_write pulse, with reg_dst=1 on cycle 4.
- LW with mem_ready low for 2 cycles in MEM_RD → 7-cycle instruction; mem_read/iord held high for 3 cycles; reg_write with mem_to_reg=1.
- BEQ then JMP back-to-back → BRANCH asserts pc_write_cond with alu_op=001; JUMP asserts pc_write with pc_src=10. 3 cycles each.
- Opcode 1010, macro on → TRAP, illegal_op=1, halted=1 persistent. Macro off → returns to FETCH in cycle 3.
- rst asserted during MEM_WR while waiting → next cycle FETCH; mem_write=0 during and after the reset cycle.
- HALT (1111) → halted=1 for 100 cycles with toggling mem_ready; no strobes asserted.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle controller, datapath and ALU control.
package mc_pkg;

  localparam logic [3:0] StFetch   = 4'd0;
  localparam logic [3:0] StDecode  = 4'd1;
  localparam logic [3:0] StExecR   = 4'd2;
  localparam logic [3:0] StExecI   = 4'd3;
  localparam logic [3:0] StRWb     = 4'd4;
  localparam logic [3:0] StIWb     = 4'd5;
  localparam logic [3:0] StMemAddr = 4'd6;
  localparam logic [3:0] StMemRd   = 4'd7;
  localparam logic [3:0] StMemWb   = 4'd8;
  localparam logic [3:0] StMemWr   = 4'd9;
  localparam logic [3:0] StBranch  = 4'd10;
  localparam logic [3:0] StJump    = 4'd11;
  localparam logic [3:0] StHalt    = 4'd12;
  localparam logic [3:0] StTrap    = 4'd13;

  localparam logic [3:0] OpRtype = 4'b0000;
  localparam logic [3:0] OpAddi  = 4'b0001;
  localparam logic [3:0] OpAndi  = 4'b0010;
  localparam logic [3:0] OpOri   = 4'b0011;
  localparam logic [3:0] OpLw    = 4'b0100;
  localparam logic [3:0] OpSw    = 4'b0101;
  localparam logic [3:0] OpBeq   = 4'b0110;
  localparam logic [3:0] OpJmp   = 4'b0111;
  localparam logic [3:0] OpHalt  = 4'b1111;

  localparam logic [2:0] AluAdd   = 3'b000;
  localparam logic [2:0] AluSub   = 3'b001;
  localparam logic [2:0] AluRtype = 3'b011;
  localparam logic [2:0] AluAndi  = 3'b110;
  localparam logic [2:0] AluOri   = 3'b111;

  localparam logic [1:0] PcSrcAlu    = 2'b00;
  localparam logic [1:0] PcSrcAluOut = 2'b01;
  localparam logic [1:0] PcSrcJump   = 2'b10;

  localparam logic [1:0] AluBReg  = 2'b00;
  localparam logic [1:0] AluBOne  = 2'b01;
  localparam logic [1:0] AluBSext = 2'b10;
  localparam logic [1:0] AluBZext = 2'b11;

  function automatic logic is_mem_state(input logic [3:0] st);
    return (st == StFetch) || (st == StMemRd) || (st == StMemWr);
  endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational control-word decode from state and latched opcode; all zero under reset.
module mc_ctrl_decode
  import mc_pkg::*;
(
  input  logic       rst,
  input  logic [3:0] state,
  input  logic [3:0] opcode_lat,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic [1:0] pc_src,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic       halted
);

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_src        = PcSrcAlu;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = AluBReg;
    alu_op        = AluAdd;
    halted        = 1'b0;
    if (!rst) begin
      case (state)
        StFetch: begin
          mem_read  = 1'b1;
          alu_src_b = AluBOne;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        StDecode: alu_src_b = AluBSext;
        StExecR: begin
          alu_src_a = 1'b1;
          alu_op    = AluRtype;
        end
        StExecI: begin
          alu_src_a = 1'b1;
          if (opcode_lat == OpAndi) begin
            alu_src_b = AluBZext;
            alu_op    = AluAndi;
          end else if (opcode_lat == OpOri) begin
            alu_src_b = AluBZext;
            alu_op    = AluOri;
          end else begin
            alu_src_b = AluBSext;
          end
        end
        StRWb: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
        end
        StIWb: reg_write = 1'b1;
        StMemAddr: begin
          alu_src_a = 1'b1;
          alu_src_b = AluBSext;
        end
        StMemRd: begin
          mem_read = 1'b1;
          iord     = 1'b1;
        end
        StMemWb: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        StMemWr: begin
          mem_write = 1'b1;
          iord      = 1'b1;
        end
        StBranch: begin
          alu_src_a     = 1'b1;
          alu_op        = AluSub;
          pc_write_cond = 1'b1;
          pc_src        = PcSrcAluOut;
        end
        StJump: begin
          pc_write = 1'b1;
          pc_src   = PcSrcJump;
        end
        StHalt, StTrap: halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mc_main_control.sv
// Main sequencing FSM of the multi-cycle CPU.
// Optional MC_CTRL_ILLEGAL_TRAP_EN: illegal opcodes / memory timeouts enter a sticky TRAP.
module mc_main_control
  import mc_pkg::*;
#(
  parameter int unsigned MEM_WAIT_MAX = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic [1:0] pc_src,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic       halted,
  output logic       illegal_op
);

  localparam int unsigned WaitW = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX + 1) : 1;

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  localparam logic [3:0] StFault = StTrap;
`else
  localparam logic [3:0] StFault = StHalt;
`endif

  logic [3:0]       state_q, state_d;
  logic [3:0]       opcode_q;
  logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
  logic             waiting, timeout;

  assign waiting = is_mem_state(state_q) && !mem_ready;
  assign timeout = (MEM_WAIT_MAX != 0) && waiting &&
                   ((32'(wait_cnt_q) + 32'd1) >= MEM_WAIT_MAX);

  always_comb begin
    state_d = state_q;
    case (state_q)
      StFetch:  if (mem_ready) state_d = StDecode;
      StDecode: begin
        case (opcode)
          OpRtype:               state_d = StExecR;
          OpAddi, OpAndi, OpOri: state_d = StExecI;
          OpLw, OpSw:            state_d = StMemAddr;
          OpBeq:                 state_d = StBranch;
          OpJmp:                 state_d = StJump;
          OpHalt:                state_d = StHalt;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
          default:               state_d = StTrap;
`else
          default:               state_d = StFetch;
`endif
        endcase
      end
      StExecR:   state_d = StRWb;
      StExecI:   state_d = StIWb;
      StMemAddr: state_d = (opcode_q == OpLw) ? StMemRd : StMemWr;
      StMemRd:   if (mem_ready) state_d = StMemWb;
      StMemWr:   if (mem_ready) state_d = StFetch;
      StRWb, StIWb, StMemWb, StBranch, StJump: state_d = StFetch;
      StHalt, StTrap: state_d = state_q;
      default:   state_d = StFetch;
    endcase
    if (timeout) state_d = StFault;
  end

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (state_d != state_q) begin
      wait_cnt_d = '0;
    end else if (waiting && (wait_cnt_q != '1)) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StFetch;
      opcode_q   <= '0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      if (state_q == StDecode) opcode_q <= opcode;
    end
  end

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  logic illegal_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      illegal_q <= 1'b0;
    end else if (state_d == StTrap) begin
      illegal_q <= 1'b1;
    end
  end

  assign illegal_op = illegal_q & ~rst;
`else
  assign illegal_op = 1'b0;
`endif

  mc_ctrl_decode u_decode (
    .rst           (rst),
    .state         (state_q),
    .opcode_lat    (opcode_q),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .pc_src        (pc_src),
    .iord          (iord),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .reg_write     (reg_write),
    .reg_dst       (reg_dst),
    .mem_to_reg    (mem_to_reg),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .halted        (halted)
  );

endmodule

// File: tb/tb_mc_main_control.sv
// Scoreboard bench for mc_main_control: per-cycle expected control words, monitor on negedge.
module tb_mc_main_control;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic       reg_write, reg_dst, mem_to_reg, alu_src_a, halted, illegal_op;
  logic [1:0] pc_src, alu_src_b;
  logic [2:0] alu_op;

  // {pc_write, pc_write_cond, pc_src, iord, mem_read, mem_write, ir_write,
  //  reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, halted, illegal_op}
  localparam logic [18:0] E_ZERO      = '0;
  localparam logic [18:0] E_FETCH_NR  = {1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0,
                                         1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 3'b000, 1'b0, 1'b0};
  localparam logic [18:0] E_FETCH_R   = {1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1,
                                         1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 3'b000, 1'b0, 1'b0};
  localparam logic [18:0] E_DECODE    = {1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0,
                                         1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 3'b000, 1'b0, 1'b0};
  localparam logic [18:0] E_EXEC_R    = {1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0,
                                         1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 3'b011, 1'b0, 1'b0};
  localparam logic [18:0] E_R_WB      = {1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0,
                                         1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 3'b000, 1'b0, 1'b0};
  localparam logic [18:0] E_EXEC_ADDI = {1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0,
                                         1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 3'b000, 1'b0, 1'b0};
  localparam logic [18:0] E_EXEC_ANDI = {1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0,
                                         1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 3'b110, 1'b0, 1'b0};
  localparam logic [18:0] E_EXEC_ORI  = {1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0,
                                         1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 3'b111, 1'b0, 1'b0};
  localparam logic [18:0] E_I_WB      = {1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0,
                                         1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 1'b0, 1'b0};
  localparam logic [18:0] E_MEM_ADDR  = E_EXEC_ADDI;
  localparam logic [18:0] E_MEM_RD    = {1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0,
                                         1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 1'b0, 1'b0};
  localparam logic [18:0] E_MEM_WB    = {1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0,
                                         1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 3'b000, 1'b0, 1'b0};
  localparam logic [18:0] E_MEM_WR    = {1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0,
                                         1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 1'b0, 1'b0};
  localparam logic [18:0] E_BRANCH    = {1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0,
                                         1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 3'b001, 1'b0, 1'b0};
  localparam logic [18:0] E_JUMP      = {1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0,
                                         1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 1'b0, 1'b0};
  localparam logic [18:0] E_HALT      = 19'b10;
  localparam logic [18:0] E_TRAP      = 19'b11;

  logic [18:0] act;
  logic [18:0] exp_q[$];
  string       name_q[$];
  logic [18:0] mon_e;
  string       mon_n;
  int          checks = 0;
  int          errors = 0;

  assign act = {pc_write, pc_write_cond, pc_src, iord, mem_read, mem_write, ir_write,
                reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, halted, illegal_op};

  mc_main_control dut (
    .clk           (clk),
    .rst           (rst),
    .opcode        (opcode),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .pc_src        (pc_src),
    .iord          (iord),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .reg_write     (reg_write),
    .reg_dst       (reg_dst),
    .mem_to_reg    (mem_to_reg),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .halted        (halted),
    .illegal_op    (illegal_op)
  );

  always #5 clk = ~clk;

  // Monitor: one expected control word per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      mon_n = name_q.pop_front();
      checks++;
      if (act !== mon_e) begin
        errors++;
        $display("FAIL %s: got %b expected %b", mon_n, act, mon_e);
      end
    end
  end

  task automatic cyc(input logic r, input logic [3:0] op, input logic rdy,
                     input logic [18:0] e, input string n);
    rst       = r;
    opcode    = op;
    mem_ready = rdy;
    exp_q.push_back(e);
    name_q.push_back(n);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; opcode = 4'h0; mem_ready = 1'b1;
    @(posedge clk);
    #1;
    cyc(1, 4'h0, 1, E_ZERO, "reset0");
    cyc(1, 4'h0, 1, E_ZERO, "reset1");

    // R-type, zero wait
    cyc(0, 4'h0, 1, E_FETCH_R, "r_fetch");
    cyc(0, 4'h0, 1, E_DECODE,  "r_decode");
    cyc(0, 4'h0, 1, E_EXEC_R,  "r_exec");
    cyc(0, 4'h0, 1, E_R_WB,    "r_wb");

    // LW, two wait cycles in MEM_RD; live opcode changed to SW after decode
    cyc(0, 4'h0, 1, E_FETCH_R,  "lw_fetch");
    cyc(0, 4'h4, 0, E_DECODE,   "lw_decode");
    cyc(0, 4'h5, 1, E_MEM_ADDR, "lw_addr");
    cyc(0, 4'h5, 0, E_MEM_RD,   "lw_rd_wait1");
    cyc(0, 4'h5, 0, E_MEM_RD,   "lw_rd_wait2");
    cyc(0, 4'h5, 1, E_MEM_RD,   "lw_rd_done");
    cyc(0, 4'h5, 1, E_MEM_WB,   "lw_wb");

    // BEQ then JMP
    cyc(0, 4'h0, 1, E_FETCH_R, "beq_fetch");
    cyc(0, 4'h6, 1, E_DECODE,  "beq_decode");
    cyc(0, 4'h7, 1, E_BRANCH,  "beq_branch");
    cyc(0, 4'h0, 1, E_FETCH_R, "jmp_fetch");
    cyc(0, 4'h7, 1, E_DECODE,  "jmp_decode");
    cyc(0, 4'h6, 1, E_JUMP,    "jmp_jump");

    // I-type variants; live opcode differs from the latched one in EXEC_I
    cyc(0, 4'h0, 1, E_FETCH_R,   "addi_fetch");
    cyc(0, 4'h1, 1, E_DECODE,    "addi_decode");
    cyc(0, 4'h2, 1, E_EXEC_ADDI, "addi_exec");
    cyc(0, 4'h2, 1, E_I_WB,      "addi_wb");
    cyc(0, 4'h0, 1, E_FETCH_R,   "andi_fetch");
    cyc(0, 4'h2, 1, E_DECODE,    "andi_decode");
    cyc(0, 4'h3, 1, E_EXEC_ANDI, "andi_exec");
    cyc(0, 4'h3, 1, E_I_WB,      "andi_wb");
    cyc(0, 4'h0, 1, E_FETCH_R,   "ori_fetch");
    cyc(0, 4'h3, 1, E_DECODE,    "ori_decode");
    cyc(0, 4'h1, 1, E_EXEC_ORI,  "ori_exec");
    cyc(0, 4'h1, 1, E_I_WB,      "ori_wb");

    // SW with one fetch wait, zero-wait store
    cyc(0, 4'h0, 0, E_FETCH_NR, "sw_fetch_wait");
    cyc(0, 4'h0, 1, E_FETCH_R,  "sw_fetch");
    cyc(0, 4'h5, 1, E_DECODE,   "sw_decode");
    cyc(0, 4'h4, 1, E_MEM_ADDR, "sw_addr");
    cyc(0, 4'h4, 1, E_MEM_WR,   "sw_wr");

    // SW abandoned by reset while waiting in MEM_WR
    cyc(0, 4'h0, 1, E_FETCH_R,  "swrst_fetch");
    cyc(0, 4'h5, 1, E_DECODE,   "swrst_decode");
    cyc(0, 4'h5, 1, E_MEM_ADDR, "swrst_addr");
    cyc(0, 4'h5, 0, E_MEM_WR,   "swrst_wait1");
    cyc(0, 4'h5, 0, E_MEM_WR,   "swrst_wait2");
    cyc(1, 4'h5, 1, E_ZERO,     "swrst_rst");
    cyc(0, 4'h5, 0, E_FETCH_NR, "swrst_after");
    cyc(0, 4'h0, 1, E_FETCH_R,  "ill_fetch");
    cyc(0, 4'hA, 1, E_DECODE,   "ill_decode");
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    for (int i = 0; i < 5; i++) cyc(0, 4'h0, i[0], E_TRAP, "trap_hold");
    cyc(1, 4'h0, 1, E_ZERO,     "trap_rst");
    cyc(0, 4'h0, 0, E_FETCH_NR, "trap_after");
`else
    cyc(0, 4'h0, 0, E_FETCH_NR, "ill_nop_fetch");
`endif

    // HALT with toggling mem_ready
    cyc(0, 4'h0, 1, E_FETCH_R, "halt_fetch");
    cyc(0, 4'hF, 1, E_DECODE,  "halt_decode");
    for (int i = 0; i < 100; i++) cyc(0, 4'h0, i[0], E_HALT, "halt_hold");
    cyc(1, 4'h0, 1, E_ZERO,    "halt_rst");
    cyc(0, 4'h0, 1, E_FETCH_R, "halt_after");

    for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
